test_status_monitor: RTL and testbench
======================================

# test_status_monitor

Synthesizable end-of-test detector and retirement statistics unit for the pipelined RISC-V core. It sits beside the writeback stage and taps the W-stage retire and CSR-write signals. It counts cycles, retired instructions and stalled cycles, and decides PASS / FAIL / TIMEOUT from writes to the test-status CSR. It replaces the bench-side cycle counting and status polling, so the same checking runs in simulation and on FPGA, generalised to multiple retire lanes and two status-encoding modes.

## Interface
Parameters:
- NUM_RETIRE, 1, number of W-stage retire lanes (1..4)
- CNT_W, 32, width of every statistics counter
- TIMEOUT_CYCLES, 1000000, RUN cycles before TIMEOUT; 0 disables the timeout
- STATUS_MODE, 0, 0 = exact match against TEST_PASS/TEST_FAIL; 1 = tohost style (1 = pass, odd ≠ 1 = fail with id = value >> 1, even = ignored)

Ports:
- clk_i  in  1  core clock
- reset_ni  in  1  synchronous, active-low reset
- valid_w_i  in  NUM_RETIRE  per-lane W-stage instruction valid
- stall_w_i  in  1  W stage stalled (applies to all lanes)
- csr_we_w_i  in  1  CSR write retiring in W (lane 0 only)
- csr_addr_w_i  in  12  CSR write address
- csr_result_w_i  in  32  CSR write data
- clear_i  in  1  pulse; leaves DONE, zeroes counters, re-enters RUN
- done_o  out  1  test finished; high in DONE
- result_o  out  2  status_e: RUNNING / PASS / FAIL / TIMEOUT
- fail_id_o  out  32  mode 0: raw status value; mode 1: value >> 1; else 0
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- retire_cnt_o  out  CNT_W  instructions retired
- stall_cnt_o  out  CNT_W  cycles with stall_w_i high

## Operation
- **FSM states.** RUN and DONE. Reset enters RUN.
- **RUN → DONE transitions.**
  - A terminating status write moves to DONE.
  - Otherwise, cycle_cnt reaching TIMEOUT_CYCLES moves to DONE.
  - DONE → RUN only on clear_i. clear_i in RUN zeroes the counters and stays in RUN.
- **Retire accounting.**
  - Each RUN cycle with stall_w_i low adds popcount(valid_w_i) to retire_cnt.
  - A cycle with stall_w_i high adds 1 to stall_cnt and 0 to retire_cnt.
- **Status write.** A status write is csr_we_w_i & ~stall_w_i & csr_addr_w_i == MTEST_STATUS_ADDR.
  - Mode 0: value TEST_PASS → PASS; TEST_FAIL → FAIL with fail_id = value; any other value is ignored (progress marker).
  - Mode 1: value 1 → PASS; odd value → FAIL with fail_id = value >> 1; even value is ignored.
- **Arithmetic.** All counters saturate at 2^CNT_W − 1 and never wrap. The retire adder is sized clog2(NUM_RETIRE+1) bits and zero-extended.
- **DONE state.** Counters and result are frozen. All inputs except clear_i are ignored.

## Timing
- **Registered outputs.** All outputs are registered; nothing is combinational from the inputs.
- **Reset values.** done_o = 0, result_o = RUNNING, fail_id_o = 0, all counters = 0.
- **Status latency.** A terminating status write sampled at edge N gives done_o/result_o valid after edge N. That write's own cycle is counted in cycle_cnt and retire_cnt.
- **Timeout.** TIMEOUT asserts on the edge where cycle_cnt becomes TIMEOUT_CYCLES; cycle_cnt_o then reads exactly TIMEOUT_CYCLES.
- **Simultaneous timeout and status write.** A PASS/FAIL status write wins over a timeout in the same cycle.
- **clear_i.** Takes effect in one cycle: next cycle result = RUNNING, done_o = 0, counters = 0. clear_i on the same edge as a terminating write: clear wins, and the write is discarded.
- **Reset mid-test.** reset_ni low at any point restores the reset values on the next edge. reset_ni has priority over clear_i and all events.

## Structure
- **tb_pkg (shared package).** Holds:
  - status_e enum (RUNNING = 0, PASS = 1, FAIL = 2, TIMEOUT = 3)
  - MTEST_STATUS_ADDR, TEST_PASS, TEST_FAIL constants, replacing the current macros
- **sat_counter sub-module.** Parametrised width and increment width, with clear and enable. Instantiated three times.
- **Bench integration.** The bench instantiates the monitor and calls $finish on done_o.

## Test plan
- **PASS write (mode 0).** Retire 10 instrs (NUM_RETIRE = 1, no stalls), then write TEST_PASS to MTEST_STATUS_ADDR → done_o = 1 the next cycle, result = PASS, retire_cnt = 11, stays frozen 20 cycles.
- **FAIL write (mode 1).** Write 0x0000_0007 → FAIL, fail_id_o = 3. A prior write of 0x0000_0004 → ignored, still RUNNING.
- **Timeout.** TIMEOUT_CYCLES = 50, no status writes → done_o after 50 RUN cycles, result = TIMEOUT, cycle_cnt = 50. A PASS write in cycle 50 → result = PASS instead.
- **Multi-lane and stalls.** NUM_RETIRE = 2, valid = 2'b11 for 4 cycles, 2'b01 for 2 cycles, stall high for 3 cycles with valid = 2'b11 → retire_cnt = 10, stall_cnt = 3. A status write during stall → ignored.
- **Saturation.** CNT_W = 4, TIMEOUT_CYCLES = 0, run 40 cycles → cycle_cnt_o holds 15.
- **clear_i and reset.** clear_i in DONE → RUNNING and zero counters the next cycle. clear_i coincident with a PASS write → RUNNING. reset_ni low mid-RUN for 1 cycle → all outputs at reset values.

Source files
------------

// File: rtl/test_status_monitor_pkg.sv
// Shared types and constants for the end-of-test status monitor.
// Holds the status encoding, the status CSR address/values and the status-write decoder.
package test_status_monitor_pkg;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } status_e;

    typedef enum logic {
        MON_RUN  = 1'b0,
        MON_DONE = 1'b1
    } mon_state_e;

    localparam logic [11:0] MTEST_STATUS_ADDR = 12'h7C0;
    localparam logic [31:0] TEST_PASS         = 32'h0000_600D;
    localparam logic [31:0] TEST_FAIL         = 32'h0000_0BAD;

    typedef struct packed {
        logic        term;
        status_e     result;
        logic [31:0] fail_id;
    } status_dec_t;

    // Decodes a status CSR value; term is set only for values that end the test.
    function automatic status_dec_t decode_status(input int mode, input logic [31:0] value);
        status_dec_t dec;
        dec.term    = 1'b0;
        dec.result  = RUNNING;
        dec.fail_id = '0;
        if (mode == 0) begin
            if (value == TEST_PASS) begin
                dec.term   = 1'b1;
                dec.result = PASS;
            end else if (value == TEST_FAIL) begin
                dec.term    = 1'b1;
                dec.result  = FAIL;
                dec.fail_id = value;
            end
        end else begin
            if (value == 32'd1) begin
                dec.term   = 1'b1;
                dec.result = PASS;
            end else if (value[0]) begin
                dec.term    = 1'b1;
                dec.result  = FAIL;
                dec.fail_id = {1'b0, value[31:1]};
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/test_status_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Adds a zero-extended increment each enabled cycle and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32,
    parameter int INC_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (WIDTH+1)'(inc_i);
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/test_status_monitor.sv
// End-of-test detector beside the W stage: decides PASS/FAIL/TIMEOUT from status CSR
// writes and keeps cycle, retire and stall statistics.
//   state    | meaning
//   MON_RUN  | test executing, counters advancing, status writes and timeout watched
//   MON_DONE | verdict latched, counters and result frozen until clear_i
module test_status_monitor
    import test_status_monitor_pkg::*;
#(
    parameter int NUM_RETIRE     = 1,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int STATUS_MODE    = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [NUM_RETIRE-1:0] valid_w_i,
    input  logic                  stall_w_i,
    input  logic                  csr_we_w_i,
    input  logic [11:0]           csr_addr_w_i,
    input  logic [31:0]           csr_result_w_i,
    input  logic                  clear_i,
    output logic                  done_o,
    output logic [1:0]            result_o,
    output logic [31:0]           fail_id_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      retire_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int RET_W = $clog2(NUM_RETIRE + 1);
    // A timeout beyond the saturated counter value can never be reached.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                           ((CNT_W >= 31) || (TIMEOUT_CYCLES < (1 << CNT_W)));
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT_CYCLES);

    mon_state_e  state_q, state_d;
    status_e     result_q, result_d;
    logic [31:0] fail_id_q, fail_id_d;

    logic [RET_W-1:0] retire_inc;
    status_dec_t      status_dec;
    logic             in_run;
    logic             status_wr;
    logic             term_write;
    logic             timeout_hit;

    always_comb begin
        retire_inc = '0;
        for (int i = 0; i < NUM_RETIRE; i++) begin
            retire_inc = retire_inc + RET_W'(valid_w_i[i]);
        end
    end

    assign in_run      = (state_q == MON_RUN);
    assign status_wr   = csr_we_w_i & ~stall_w_i & (csr_addr_w_i == MTEST_STATUS_ADDR);
    assign status_dec  = decode_status(STATUS_MODE, csr_result_w_i);
    assign term_write  = in_run & status_wr & status_dec.term;
    assign timeout_hit = TO_EN & in_run & ((cycle_cnt_o + CNT_W'(1)) == TO_V);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        fail_id_d = fail_id_q;
        if (clear_i) begin
            state_d   = MON_RUN;
            result_d  = RUNNING;
            fail_id_d = '0;
        end else if (term_write) begin
            state_d   = MON_DONE;
            result_d  = status_dec.result;
            fail_id_d = status_dec.fail_id;
        end else if (timeout_hit) begin
            state_d   = MON_DONE;
            result_d  = TIMEOUT;
            fail_id_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= MON_RUN;
            result_q  <= RUNNING;
            fail_id_q <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            fail_id_q <= fail_id_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (1)
    ) u_cycle_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (clear_i),
        .en_i     (in_run),
        .inc_i    (1'b1),
        .cnt_o    (cycle_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (RET_W)
    ) u_retire_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (clear_i),
        .en_i     (in_run & ~stall_w_i),
        .inc_i    (retire_inc),
        .cnt_o    (retire_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (1)
    ) u_stall_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (clear_i),
        .en_i     (in_run & stall_w_i),
        .inc_i    (1'b1),
        .cnt_o    (stall_cnt_o)
    );

    assign done_o    = (state_q == MON_DONE);
    assign result_o  = result_q;
    assign fail_id_o = fail_id_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: two differently-parameterised instances share stimulus,
// checked by vector table, directed sequences and a randomized run against a model.
module tb_test_status_monitor;
    import test_status_monitor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [1:0]  valid   = '0;
    logic        stall   = 1'b0;
    logic        we      = 1'b0;
    logic [11:0] addr    = '0;
    logic [31:0] data    = '0;
    logic        clr     = 1'b0;

    // u0: 2 lanes, 16-bit counters, timeout 50, exact-match status
    logic        done0;
    logic [1:0]  res0;
    logic [31:0] fid0;
    logic [15:0] cyc0, ret0, stl0;
    // u1: 1 lane, 4-bit counters, no timeout, tohost status
    logic        done1;
    logic [1:0]  res1;
    logic [31:0] fid1;
    logic [3:0]  cyc1, ret1, stl1;

    test_status_monitor #(
        .NUM_RETIRE(2), .CNT_W(16), .TIMEOUT_CYCLES(50), .STATUS_MODE(0)
    ) u0 (
        .clk_i(clk), .reset_ni(reset_n), .valid_w_i(valid), .stall_w_i(stall),
        .csr_we_w_i(we), .csr_addr_w_i(addr), .csr_result_w_i(data), .clear_i(clr),
        .done_o(done0), .result_o(res0), .fail_id_o(fid0),
        .cycle_cnt_o(cyc0), .retire_cnt_o(ret0), .stall_cnt_o(stl0)
    );

    test_status_monitor #(
        .NUM_RETIRE(1), .CNT_W(4), .TIMEOUT_CYCLES(0), .STATUS_MODE(1)
    ) u1 (
        .clk_i(clk), .reset_ni(reset_n), .valid_w_i(valid[0]), .stall_w_i(stall),
        .csr_we_w_i(we), .csr_addr_w_i(addr), .csr_result_w_i(data), .clear_i(clr),
        .done_o(done1), .result_o(res1), .fail_id_o(fid1),
        .cycle_cnt_o(cyc1), .retire_cnt_o(ret1), .stall_cnt_o(stl1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state and per-instance configuration
    longint m_done[2] = '{0, 0};
    longint m_res[2]  = '{0, 0};
    longint m_fid[2]  = '{0, 0};
    longint m_cyc[2]  = '{0, 0};
    longint m_ret[2]  = '{0, 0};
    longint m_stl[2]  = '{0, 0};
    longint max_p[2]  = '{65535, 15};
    longint to_p[2]   = '{50, 0};
    int     mode_p[2] = '{0, 1};

    typedef struct {
        int          rn, v, st, w;
        logic [31:0] d;
        int          c;
        int          e_done, e_res, e_cyc, e_ret, e_stl;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint x, input int k);
        return (x > max_p[k]) ? max_p[k] : x;
    endfunction

    task automatic model_step();
        longint pop, old_cyc, v, id;
        int     r;
        bit     sw;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n || clr) begin
                m_done[k] = 0; m_res[k] = 0; m_fid[k] = 0;
                m_cyc[k] = 0; m_ret[k] = 0; m_stl[k] = 0;
            end else if (m_done[k] == 0) begin
                pop = (k == 0) ? longint'(valid[0]) + longint'(valid[1]) : longint'(valid[0]);
                old_cyc = m_cyc[k];
                m_cyc[k] = sat(m_cyc[k] + 1, k);
                if (stall) m_stl[k] = sat(m_stl[k] + 1, k);
                else       m_ret[k] = sat(m_ret[k] + pop, k);
                v  = longint'(data);
                r  = 0;
                id = 0;
                sw = we && !stall && (addr == MTEST_STATUS_ADDR);
                if (mode_p[k] == 0) begin
                    if (v == longint'(TEST_PASS)) r = 1;
                    else if (v == longint'(TEST_FAIL)) begin r = 2; id = v; end
                end else begin
                    if (v == 1) r = 1;
                    else if (v % 2 == 1) begin r = 2; id = v / 2; end
                end
                if (sw && r != 0) begin
                    m_done[k] = 1; m_res[k] = r; m_fid[k] = id;
                end else if (to_p[k] != 0 && m_cyc[k] == to_p[k] && old_cyc != m_cyc[k]) begin
                    m_done[k] = 1; m_res[k] = 3; m_fid[k] = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("m0_done", longint'(done0), m_done[0]);
        chk("m0_res",  longint'(res0),  m_res[0]);
        chk("m0_fid",  longint'(fid0),  m_fid[0]);
        chk("m0_cyc",  longint'(cyc0),  m_cyc[0]);
        chk("m0_ret",  longint'(ret0),  m_ret[0]);
        chk("m0_stl",  longint'(stl0),  m_stl[0]);
        chk("m1_done", longint'(done1), m_done[1]);
        chk("m1_res",  longint'(res1),  m_res[1]);
        chk("m1_fid",  longint'(fid1),  m_fid[1]);
        chk("m1_cyc",  longint'(cyc1),  m_cyc[1]);
        chk("m1_ret",  longint'(ret1),  m_ret[1]);
        chk("m1_stl",  longint'(stl1),  m_stl[1]);
    endtask

    task automatic set_in(input int rn, input int v, input int st, input int w,
                          input logic [31:0] d, input int c);
        reset_n = (rn != 0);
        valid   = 2'(v);
        stall   = (st != 0);
        we      = (w != 0);
        addr    = (w != 0) ? MTEST_STATUS_ADDR : 12'h300;
        data    = d;
        clr     = (c != 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        //            rn v st w  d          c  done res cyc ret stl
        tbl[0]  = '{0, 0, 0, 0, 32'd0,     0, 0, 0, 0,  0,  0};
        tbl[1]  = '{1, 3, 0, 0, 32'd0,     0, 0, 0, 1,  2,  0};
        tbl[2]  = '{1, 3, 0, 0, 32'd0,     0, 0, 0, 2,  4,  0};
        tbl[3]  = '{1, 3, 0, 0, 32'd0,     0, 0, 0, 3,  6,  0};
        tbl[4]  = '{1, 3, 0, 0, 32'd0,     0, 0, 0, 4,  8,  0};
        tbl[5]  = '{1, 1, 0, 0, 32'd0,     0, 0, 0, 5,  9,  0};
        tbl[6]  = '{1, 1, 0, 0, 32'd0,     0, 0, 0, 6,  10, 0};
        tbl[7]  = '{1, 3, 1, 0, 32'd0,     0, 0, 0, 7,  10, 1};
        tbl[8]  = '{1, 3, 1, 1, TEST_PASS, 0, 0, 0, 8,  10, 2};
        tbl[9]  = '{1, 3, 1, 0, 32'd0,     0, 0, 0, 9,  10, 3};
        tbl[10] = '{1, 0, 0, 1, TEST_PASS, 0, 1, 1, 10, 10, 3};
        tbl[11] = '{1, 3, 0, 0, 32'd0,     0, 1, 1, 10, 10, 3};
        tbl[12] = '{1, 0, 0, 0, 32'd0,     1, 0, 0, 0,  0,  0};
        tbl[13] = '{1, 1, 0, 0, 32'd0,     0, 0, 0, 1,  1,  0};
        tbl[14] = '{1, 1, 0, 1, TEST_PASS, 1, 0, 0, 0,  0,  0};
        tbl[15] = '{1, 0, 0, 0, 32'd0,     0, 0, 0, 1,  0,  0};

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].rn, tbl[i].v, tbl[i].st, tbl[i].w, tbl[i].d, tbl[i].c);
            tick();
            chk("tbl_done", longint'(done0), tbl[i].e_done);
            chk("tbl_res",  longint'(res0),  tbl[i].e_res);
            chk("tbl_cyc",  longint'(cyc0),  tbl[i].e_cyc);
            chk("tbl_ret",  longint'(ret0),  tbl[i].e_ret);
            chk("tbl_stl",  longint'(stl0),  tbl[i].e_stl);
        end

        // PASS write after 10 single-lane retirements, then frozen for 20 cycles
        set_in(0, 0, 0, 0, 32'd0, 0); tick();
        for (int i = 0; i < 10; i++) begin set_in(1, 1, 0, 0, 32'd0, 0); tick(); end
        chk("pass_pre_done", longint'(done0), 0);
        set_in(1, 1, 0, 1, TEST_PASS, 0); tick();
        chk("pass_done", longint'(done0), 1);
        chk("pass_res",  longint'(res0), 1);
        chk("pass_ret",  longint'(ret0), 11);
        for (int i = 0; i < 20; i++) begin
            set_in(1, 3, i % 2, 1, TEST_FAIL, 0); tick();
            chk("frozen_res", longint'(res0), 1);
            chk("frozen_ret", longint'(ret0), 11);
            chk("frozen_cyc", longint'(cyc0), 11);
        end

        // tohost mode: even value ignored, odd value fails with id = value >> 1
        set_in(0, 0, 0, 0, 32'd0, 0); tick();
        set_in(1, 1, 0, 1, 32'h4, 0); tick();
        chk("tohost_even_done", longint'(done1), 0);
        chk("tohost_even_res",  longint'(res1), 0);
        set_in(1, 1, 0, 1, 32'h7, 0); tick();
        chk("tohost_fail_res", longint'(res1), 2);
        chk("tohost_fail_id",  longint'(fid1), 3);

        // Timeout after exactly 50 RUN cycles
        set_in(0, 0, 0, 0, 32'd0, 0); tick();
        for (int i = 0; i < 49; i++) begin set_in(1, 0, 0, 0, 32'd0, 0); tick(); end
        chk("to_early_done", longint'(done0), 0);
        tick();
        chk("to_done", longint'(done0), 1);
        chk("to_res",  longint'(res0), 3);
        chk("to_cyc",  longint'(cyc0), 50);

        // PASS write in cycle 50 beats the timeout
        set_in(0, 0, 0, 0, 32'd0, 0); tick();
        for (int i = 0; i < 49; i++) begin set_in(1, 0, 0, 0, 32'd0, 0); tick(); end
        set_in(1, 0, 0, 1, TEST_PASS, 0); tick();
        chk("to_pass_res", longint'(res0), 1);
        chk("to_pass_cyc", longint'(cyc0), 50);

        // Saturation of the 4-bit counters
        set_in(0, 0, 0, 0, 32'd0, 0); tick();
        for (int i = 0; i < 40; i++) begin set_in(1, 1, 0, 0, 32'd0, 0); tick(); end
        chk("sat_cyc",  longint'(cyc1), 15);
        chk("sat_ret",  longint'(ret1), 15);
        chk("sat_done", longint'(done1), 0);

        // Reset mid-run has priority over clear and a status write
        for (int i = 0; i < 5; i++) begin set_in(1, 3, i % 2, 0, 32'd0, 0); tick(); end
        set_in(0, 3, 0, 1, TEST_PASS, 1); tick();
        chk("rst_done", longint'(done0), 0);
        chk("rst_res",  longint'(res0), 0);
        chk("rst_cyc",  longint'(cyc0), 0);
        chk("rst_ret",  longint'(ret0), 0);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            valid   = 2'($urandom);
            stall   = ($urandom_range(0, 3) == 0);
            we      = ($urandom_range(0, 2) == 0);
            addr    = ($urandom_range(0, 1) != 0) ? MTEST_STATUS_ADDR : 12'($urandom);
            case ($urandom_range(0, 5))
                0:       data = TEST_PASS;
                1:       data = TEST_FAIL;
                2:       data = 32'd1;
                3:       data = 32'd7;
                4:       data = 32'd4;
                default: data = $urandom;
            endcase
            clr = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
